scene_sequencer: RTL and testbench

Frame-synchronous controller that drives the 8-bit `vga_control` byte of the pixel colour datapath from a small built-in script. It replaces manual control-byte toggling for demo playback. The script steps through background modes and sprite selection, each held for a programmed number of frames. It also issues the multi-cycle write sequence that loads the solid-colour register one 2-bit channel at a time. It sits between the top level and the pixel colour block and shares its `clk` and `vsync`.

---
 rtl/scene_seq_pkg.sv | 40 ++++
 rtl/scene_sequencer_if.sv | 24 ++
 rtl/scene_script_rom.sv | 39 +++
 rtl/scene_sequencer.sv | 122 ++++++++++++
 tb/tb_scene_sequencer.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scene_seq_pkg.sv
// Shared definitions for the scene sequencer: script entry layout, FSM states,
// channel-write prefixes and the idle control byte.
package scene_seq_pkg;

  localparam int unsigned ENTRY_W  = 16;
  localparam int unsigned KIND_BIT = 15;
  localparam int unsigned DUR_LSB  = 8;
  localparam int unsigned DUR_W    = 7;
  localparam int unsigned PAY_LSB  = 0;
  localparam int unsigned PAY_W    = 8;
  localparam int unsigned CTRL_W   = 8;

  localparam logic [2:0]        PFX_R      = 3'b100;
  localparam logic [2:0]        PFX_G      = 3'b010;
  localparam logic [2:0]        PFX_B      = 3'b001;
  localparam logic [CTRL_W-1:0] CTRL_RESET = 8'h00;
  // Scene bytes never select the colour-write bits [7:6]
  localparam logic [CTRL_W-1:0] SCENE_MASK = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SCENE,
    ST_PROG_R,
    ST_PROG_G,
    ST_PROG_B
  } state_e;

  typedef struct packed {
    logic             kind;
    logic [DUR_W-1:0] duration;
    logic [PAY_W-1:0] payload;
  } entry_t;

  function automatic logic [CTRL_W-1:0] chan_byte(input logic [2:0] pfx, input logic [1:0] ch);
    return {pfx, 3'b000, ch};
  endfunction

endpackage

// File: rtl/scene_sequencer_if.sv
// Control/status bundle between the top level and the scene sequencer.
interface scene_sequencer_if #(
  parameter int unsigned IDX_W = 4
);
  logic             vsync;
  logic             enable;
  logic             pause;
  logic             skip;
  logic             manual_en;
  logic [7:0]       manual_control;
  logic [7:0]       vga_control;
  logic [IDX_W-1:0] scene_idx;
  logic             busy;

  modport master (
    output vsync, enable, pause, skip, manual_en, manual_control,
    input  vga_control, scene_idx, busy
  );

  modport slave (
    input  vsync, enable, pause, skip, manual_en, manual_control,
    output vga_control, scene_idx, busy
  );
endinterface

// File: rtl/scene_script_rom.sv
// Registered script ROM: one 16-bit entry per index, read latency one cycle.
module scene_script_rom
  import scene_seq_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] addr_i,
  output entry_t           data_o
);

  entry_t data_q;

  // {kind, duration, payload}; duration is ignored by colour-program entries
  always_ff @(posedge clk) begin
    case (32'(addr_i))
      32'd0:   data_q <= entry_t'(16'h0301);
      32'd1:   data_q <= entry_t'(16'h8036);
      32'd2:   data_q <= entry_t'(16'h0005);
      32'd3:   data_q <= entry_t'(16'h020A);
      32'd4:   data_q <= entry_t'(16'h801B);
      32'd5:   data_q <= entry_t'(16'h0112);
      32'd6:   data_q <= entry_t'(16'h02C7);
      32'd7:   data_q <= entry_t'(16'hFF2D);
      32'd8:   data_q <= entry_t'(16'h0120);
      32'd9:   data_q <= entry_t'(16'h023F);
      32'd10:  data_q <= entry_t'(16'h8000);
      32'd11:  data_q <= entry_t'(16'h0115);
      32'd12:  data_q <= entry_t'(16'h032A);
      32'd13:  data_q <= entry_t'(16'h803F);
      32'd14:  data_q <= entry_t'(16'h0108);
      32'd15:  data_q <= entry_t'(16'h020C);
      default: data_q <= entry_t'(16'h0100);
    endcase
  end

  assign data_o = data_q;

endmodule

// File: rtl/scene_sequencer.sv
// Frame-synchronous script player driving the pixel block's control byte.
// Define SCENE_SEQ_MANUAL_EN to build the manual control-byte override.
module scene_sequencer
  import scene_seq_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned IDX_W       = 4
) (
  input logic              clk,
  input logic              rst,
  scene_sequencer_if.slave seq_if
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DUR_W-1:0]    cnt_q;
  logic [PAY_W-1:0]    pay_q;
  logic [CTRL_W-1:0]   fsm_ctrl_q;
  logic                busy_q;
  logic                vsync_q;
  logic                tick_q;
  entry_t              rom_data;
  logic [IDX_W-1:0]    idx_next_c;
  logic                frame_c;

  scene_script_rom #(.IDX_W(IDX_W)) u_rom (
    .clk    (clk),
    .addr_i (idx_q),
    .data_o (rom_data)
  );

  // vsync_q resets high so a vsync already asserted at reset is not a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      vsync_q <= seq_if.vsync;
      tick_q  <= seq_if.vsync & ~vsync_q;
    end
  end

  assign idx_next_c = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
  assign frame_c    = tick_q & ~seq_if.pause;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      pay_q      <= '0;
      fsm_ctrl_q <= CTRL_RESET;
      busy_q     <= 1'b0;
    end else if (!seq_if.enable) begin
      state_q    <= ST_IDLE;
      fsm_ctrl_q <= CTRL_RESET;
      busy_q     <= 1'b0;
    end else begin
      busy_q <= 1'b1;
      case (state_q)
        ST_IDLE:  state_q <= ST_FETCH;
        ST_FETCH: state_q <= ST_LOAD;
        ST_LOAD: begin
          pay_q   <= rom_data.payload;
          cnt_q   <= rom_data.duration;
          state_q <= rom_data.kind ? ST_PROG_R : ST_SCENE;
        end
        ST_SCENE: begin
          fsm_ctrl_q <= pay_q & SCENE_MASK;
          // A zero count never reaches 1, so duration 0 holds until skip
          if (seq_if.skip || (frame_c && cnt_q == DUR_W'(1))) begin
            idx_q   <= idx_next_c;
            state_q <= ST_FETCH;
          end else if (frame_c && cnt_q != '0) begin
            cnt_q <= cnt_q - DUR_W'(1);
          end
        end
        ST_PROG_R: begin
          fsm_ctrl_q <= chan_byte(PFX_R, pay_q[5:4]);
          state_q    <= ST_PROG_G;
        end
        ST_PROG_G: begin
          fsm_ctrl_q <= chan_byte(PFX_G, pay_q[3:2]);
          state_q    <= ST_PROG_B;
        end
        ST_PROG_B: begin
          fsm_ctrl_q <= chan_byte(PFX_B, pay_q[1:0]);
          idx_q      <= idx_next_c;
          state_q    <= ST_FETCH;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef SCENE_SEQ_MANUAL_EN
  logic              man_en_q;
  logic [CTRL_W-1:0] man_ctrl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      man_en_q   <= 1'b0;
      man_ctrl_q <= CTRL_RESET;
    end else begin
      man_en_q   <= seq_if.manual_en;
      man_ctrl_q <= seq_if.manual_control;
    end
  end

  assign seq_if.vga_control = man_en_q ? man_ctrl_q : fsm_ctrl_q;
`else
  logic unused_manual;
  assign unused_manual      = ^{seq_if.manual_en, seq_if.manual_control};
  assign seq_if.vga_control = fsm_ctrl_q;
`endif

  assign seq_if.scene_idx = idx_q;
  assign seq_if.busy      = busy_q;

endmodule

// File: tb/tb_scene_sequencer.sv
// Self-checking bench for scene_sequencer: directed vector table, hand-written
// corner sequences, then randomized stimulus against a frame-level script model.
module tb_scene_sequencer;

  localparam int unsigned IDX_W       = 4;
  localparam int unsigned NUM_ENTRIES = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   model_chk = 1'b0;

  scene_sequencer_if #(.IDX_W(IDX_W)) seq_if ();

  scene_sequencer #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .seq_if (seq_if)
  );

  always #5 clk = ~clk;

  // The demo script as authored: {kind, duration[6:0], payload[7:0]}
  logic [15:0] script [NUM_ENTRIES] = '{
    16'h0301, 16'h8036, 16'h0005, 16'h020A, 16'h801B, 16'h0112, 16'h02C7, 16'hFF2D,
    16'h0120, 16'h023F, 16'h8000, 16'h0115, 16'h032A, 16'h803F, 16'h0108, 16'h020C
  };

  // Reference model: which entry plays, how long since it was fetched, frames seen
  int         m_idx, m_age, m_frames;
  bit         m_run, m_prev_vs, m_tick;
  logic [7:0] m_vga;
`ifdef SCENE_SEQ_MANUAL_EN
  bit         m_man_en;
  logic [7:0] m_man_ctrl;
`endif

  function automatic void m_advance();
    m_idx = (m_idx + 1) % NUM_ENTRIES;
    m_age = 0;
  endfunction

  function automatic void model_step();
    bit          tick_now;
    logic [15:0] e;
    int          k;
    if (rst) begin
      m_idx = 0; m_age = 0; m_frames = 0; m_run = 1'b0;
      m_vga = 8'h00; m_prev_vs = 1'b1; m_tick = 1'b0;
`ifdef SCENE_SEQ_MANUAL_EN
      m_man_en = 1'b0; m_man_ctrl = 8'h00;
`endif
      return;
    end
    tick_now  = m_tick;
    m_tick    = seq_if.vsync && !m_prev_vs;
    m_prev_vs = seq_if.vsync;
`ifdef SCENE_SEQ_MANUAL_EN
    m_man_en   = seq_if.manual_en;
    m_man_ctrl = seq_if.manual_control;
`endif
    if (!seq_if.enable) begin
      m_run = 1'b0;
      m_vga = 8'h00;
      return;
    end
    if (!m_run) begin
      m_run = 1'b1;
      m_age = 0;
      return;
    end
    e = script[m_idx];
    if (m_age < 2) begin
      m_age++;
      m_frames = 0;
      return;
    end
    if (e[15]) begin
      k     = m_age - 2;
      m_vga = 8'(32'h80 >> k) | 8'((e[5:0] >> (2 * (2 - k))) & 6'h3);
      if (k == 2) m_advance();
      else        m_age++;
    end else begin
      m_vga = {2'b00, e[5:0]};
      if (seq_if.skip) begin
        m_advance();
      end else if (tick_now && !seq_if.pause) begin
        m_frames++;
        if (e[14:8] != 7'd0 && m_frames == int'(e[14:8])) m_advance();
      end
    end
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic step(input bit r, input bit en, input bit vs, input bit sk, input bit pa,
                      input bit man, input logic [7:0] mc);
    logic [7:0] ev;
    @(negedge clk);
    rst                   = r;
    seq_if.enable         = en;
    seq_if.vsync          = vs;
    seq_if.skip           = sk;
    seq_if.pause          = pa;
    seq_if.manual_en      = man;
    seq_if.manual_control = mc;
    @(posedge clk);
    model_step();
    #1;
    if (model_chk) begin
      ev = m_vga;
`ifdef SCENE_SEQ_MANUAL_EN
      if (m_man_en) ev = m_man_ctrl;
`endif
      check("rand vga_control", 32'(seq_if.vga_control), 32'(ev));
      check("rand scene_idx", 32'(seq_if.scene_idx), 32'(m_idx));
      check("rand busy", 32'(seq_if.busy), 32'(m_run));
    end
  endtask

  bit         c_en, c_pa, c_man;
  logic [7:0] c_mc;

  task automatic cyc(input bit vs, input bit sk);
    step(1'b0, c_en, vs, sk, c_pa, c_man, c_mc);
  endtask

  task automatic frame();
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
  endtask

  typedef struct {
    bit         en;
    bit         vs;
    logic [7:0] vga;
    logic [3:0] idx;
    bit         busy;
  } vec_t;

  function automatic vec_t mk(bit en, bit vs, logic [7:0] vga, logic [3:0] idx, bit busy);
    vec_t v;
    v.en = en; v.vs = vs; v.vga = vga; v.idx = idx; v.busy = busy;
    return v;
  endfunction

  vec_t vecs [25];

  initial begin
    bit r_vs;
    bit found;

    rst = 1'b1; seq_if.enable = 1'b0; seq_if.vsync = 1'b0; seq_if.skip = 1'b0;
    seq_if.pause = 1'b0; seq_if.manual_en = 1'b0; seq_if.manual_control = 8'h00;
    c_en = 1'b1; c_pa = 1'b0; c_man = 1'b0; c_mc = 8'h00;

    // Idle through 3 vsyncs, then entry 0 (01 for 3 frames) and entry 1 (program 110110)
    vecs[0]  = mk(0, 0, 8'h00, 0, 0);
    vecs[1]  = mk(0, 1, 8'h00, 0, 0);
    vecs[2]  = mk(0, 0, 8'h00, 0, 0);
    vecs[3]  = mk(0, 1, 8'h00, 0, 0);
    vecs[4]  = mk(0, 0, 8'h00, 0, 0);
    vecs[5]  = mk(0, 1, 8'h00, 0, 0);
    vecs[6]  = mk(0, 0, 8'h00, 0, 0);
    vecs[7]  = mk(1, 0, 8'h00, 0, 1);
    vecs[8]  = mk(1, 0, 8'h00, 0, 1);
    vecs[9]  = mk(1, 0, 8'h00, 0, 1);
    vecs[10] = mk(1, 0, 8'h01, 0, 1);
    vecs[11] = mk(1, 1, 8'h01, 0, 1);
    vecs[12] = mk(1, 0, 8'h01, 0, 1);
    vecs[13] = mk(1, 1, 8'h01, 0, 1);
    vecs[14] = mk(1, 0, 8'h01, 0, 1);
    vecs[15] = mk(1, 1, 8'h01, 0, 1);
    vecs[16] = mk(1, 0, 8'h01, 1, 1);
    vecs[17] = mk(1, 0, 8'h01, 1, 1);
    vecs[18] = mk(1, 0, 8'h01, 1, 1);
    vecs[19] = mk(1, 0, 8'h83, 1, 1);
    vecs[20] = mk(1, 0, 8'h41, 1, 1);
    vecs[21] = mk(1, 0, 8'h22, 2, 1);
    vecs[22] = mk(1, 0, 8'h22, 2, 1);
    vecs[23] = mk(1, 0, 8'h22, 2, 1);
    vecs[24] = mk(1, 0, 8'h05, 2, 1);

    step(1, 0, 0, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 25; i++) begin
      step(1'b0, vecs[i].en, vecs[i].vs, 1'b0, 1'b0, 1'b0, 8'h00);
      check($sformatf("vec%0d vga_control", i), 32'(seq_if.vga_control), 32'(vecs[i].vga));
      check($sformatf("vec%0d scene_idx", i), 32'(seq_if.scene_idx), 32'(vecs[i].idx));
      check($sformatf("vec%0d busy", i), 32'(seq_if.busy), 32'(vecs[i].busy));
    end

    // Duration-0 scene holds through 10 frames until skip
    for (int i = 0; i < 10; i++) frame();
    check("hold0 vga", 32'(seq_if.vga_control), 32'h05);
    check("hold0 idx", 32'(seq_if.scene_idx), 32'd2);
    cyc(1'b0, 1'b1);
    check("skip idx", 32'(seq_if.scene_idx), 32'd3);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    check("skip latency vga", 32'(seq_if.vga_control), 32'h05);
    cyc(1'b0, 1'b0);
    check("skip new vga", 32'(seq_if.vga_control), 32'h0A);

    // 2-frame scene with 4 paused frames lasts 6 frames
    c_pa = 1'b1;
    for (int i = 0; i < 4; i++) frame();
    c_pa = 1'b0;
    frame();
    check("pause idx held", 32'(seq_if.scene_idx), 32'd3);
    frame();
    check("pause idx adv", 32'(seq_if.scene_idx), 32'd4);

    // Skip during PROG_G is dropped, not queued
    cyc(1'b0, 1'b0);
    check("prog R", 32'(seq_if.vga_control), 32'h81);
    cyc(1'b0, 1'b1);
    check("prog G", 32'(seq_if.vga_control), 32'h42);
    cyc(1'b0, 1'b0);
    check("prog B", 32'(seq_if.vga_control), 32'h23);
    check("prog idx", 32'(seq_if.scene_idx), 32'd5);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    check("no queued skip vga", 32'(seq_if.vga_control), 32'h12);
    check("no queued skip idx", 32'(seq_if.scene_idx), 32'd5);

    // Skip through to the last entry and wrap
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      cyc(1'b0, 1'b1);
      if (seq_if.scene_idx == 4'd15) found = 1'b1;
    end
    check("reach last entry", 32'(found), 32'd1);
    cyc(1'b0, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    check("last vga", 32'(seq_if.vga_control), 32'h0C);
    cyc(1'b0, 1'b1);
    check("wrap idx", 32'(seq_if.scene_idx), 32'd0);
    cyc(1'b0, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    check("wrap vga", 32'(seq_if.vga_control), 32'h01);

    // Enable dropped mid-scene, then resumed on the same entry
    c_en = 1'b0;
    cyc(1'b0, 1'b0);
    check("disable vga", 32'(seq_if.vga_control), 32'h00);
    check("disable busy", 32'(seq_if.busy), 32'd0);
    check("disable idx", 32'(seq_if.scene_idx), 32'd0);
    c_en = 1'b1;
    cyc(1'b0, 1'b0);
    check("resume busy", 32'(seq_if.busy), 32'd1);
    cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    check("resume pre vga", 32'(seq_if.vga_control), 32'h00);
    cyc(1'b0, 1'b0);
    check("resume vga", 32'(seq_if.vga_control), 32'h01);

    c_man = 1'b1; c_mc = 8'hA3;
    cyc(1'b0, 1'b0);
`ifdef SCENE_SEQ_MANUAL_EN
    check("manual on vga", 32'(seq_if.vga_control), 32'hA3);
`else
    check("manual ignored vga", 32'(seq_if.vga_control), 32'h01);
`endif
    c_man = 1'b0;
    cyc(1'b0, 1'b0);
    check("manual off vga", 32'(seq_if.vga_control), 32'h01);

    // Reset in the middle of a scene
    step(1, 1, 0, 0, 0, 0, 8'h00);
    check("midrst vga", 32'(seq_if.vga_control), 32'h00);
    check("midrst idx", 32'(seq_if.scene_idx), 32'd0);
    check("midrst busy", 32'(seq_if.busy), 32'd0);

    // Randomized run against the model
    model_chk = 1'b1;
    r_vs = 1'b0; c_en = 1'b1; c_pa = 1'b0; c_man = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 79) == 0) c_en = ~c_en;
      if ($urandom_range(0, 29) == 0) c_pa = ~c_pa;
      if ($urandom_range(0, 39) == 0) c_man = ~c_man;
      if ($urandom_range(0, 4) == 0)  r_vs = ~r_vs;
      c_mc = 8'($urandom);
      step(($urandom_range(0, 999) == 0), c_en, r_vs, ($urandom_range(0, 24) == 0),
           c_pa, c_man, c_mc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
